button_conditioner: RTL and testbench
=====================================

# button_conditioner

Multi-channel push-button conditioner between the ULX3S board pins and the sorting accelerator control logic. It generalises the fixed two-button (`a_i`, `c_i`) handling into a channel-parametrised block. Each channel provides optional synchronisation, counter-based debounce, press/release strobes and hold-to-auto-repeat. The top level instantiates one copy for all front-panel buttons.

## Interface
- `NumChannels`, default 2: number of independent button channels, at least 1.
- `DebounceCycles`, default 250000: consecutive stable samples required to accept a level change (10 ms at 25 MHz), at least 1.
- `HoldCycles`, default 12500000: cycles in PRESSED before the first `repeat_o` strobe (0.5 s), at least 1.
- `RepeatCycles`, default 2500000: cycles between subsequent `repeat_o` strobes (0.1 s), at least 1.

Ports:
- `clk_i`  in  1: single system clock.
- `rst_i`  in  1: reset, synchronous and active-high.
- `btn_i`  in  NumChannels: raw button levels, active-high, asynchronous to `clk_i` unless noted under Configuration.
- `level_o`  out  NumChannels: debounced level per channel.
- `press_o`  out  NumChannels: one-cycle strobe on an accepted 0→1 change.
- `release_o`  out  NumChannels: one-cycle strobe on an accepted 1→0 change.
- `repeat_o`  out  NumChannels: one-cycle auto-repeat strobe while held.

## Operation
- Each channel is fully independent. There is no cross-channel arbitration, and simultaneous events on different channels are all reported in the same cycle.
- Per-channel FSM, sampling `s` (the post-sync sample):
  - RELEASED: if `s`=1, go to PRESS_PEND with `cnt`=1.
  - PRESS_PEND: if `s`=0, return to RELEASED. Otherwise increment `cnt`. When `cnt` equals DebounceCycles, go to PRESSED, set `level_o`, pulse `press_o`, and clear `hold_cnt`.
  - PRESSED: if `s`=0, go to RELEASE_PEND with `cnt`=1. Otherwise run the hold/repeat counter.
  - RELEASE_PEND: if `s`=1, return to PRESSED. `hold_cnt` keeps its value and repeat timing resumes without restart. Otherwise increment `cnt`. When `cnt` equals DebounceCycles, go to RELEASED, clear `level_o`, and pulse `release_o`.
- A glitch shorter than DebounceCycles samples produces no output change and no strobe.
- With DebounceCycles=1, a change is accepted on the first differing sample. The PEND state is still visited for one cycle.
- Hold/repeat while PRESSED:
  - `hold_cnt` increments each cycle.
  - When it reaches HoldCycles, pulse `repeat_o` and reload `hold_cnt` to HoldCycles−RepeatCycles. Successive strobes are therefore RepeatCycles apart.
  - Counter width is `$clog2(max(HoldCycles,RepeatCycles)+1)`. The counter never wraps.
- `press_o`, `release_o` and `repeat_o` are mutually exclusive within one channel in any cycle.
- Reset mid-operation forces every channel to RELEASED and clears all counters and outputs. A button still held after reset must be debounced again, then produces `press_o`.

## Timing
- Reset value of every output is 0, and of every counter is 0. Synchronisers reset to 0.
- Let S be the synchroniser delay: S=2 with `BUTTON_SYNC_EN`, S=0 without.
- `level_o` rises, and `press_o` pulses, in the cycle after DebounceCycles+S clock edges. Edge 1 is the first edge sampling `btn_i`=1 and the input stays high throughout.
- Release has the same latency.
- The first `repeat_o` fires HoldCycles cycles after the `press_o` cycle, then every RepeatCycles cycles.
- All outputs are registered. There are no combinational paths from `btn_i`.

## Configuration
- `BUTTON_SYNC_EN` defined:
  - Each `btn_i` bit passes through a two-flop synchroniser before the FSM.
  - Use this for board pins.
- Not defined:
  - `btn_i` is sampled directly and must already be synchronous to `clk_i`.
  - Latency drops by 2 cycles.

## Structure
- `config_pkg` holds `btn_state_e` (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND) and the default timing constants (`BtnDebounceCycles`, `BtnHoldCycles`, `BtnRepeatCycles`).
- Sub-module `button_channel` implements one channel: synchroniser, FSM and counters. It is instantiated NumChannels times via a generate loop.

## Test plan
Bench parameters: NumChannels=2, DebounceCycles=4, HoldCycles=10, RepeatCycles=3. `BUTTON_SYNC_EN` is defined unless a scenario says otherwise.
- Clean press: ch0 high for 30 cycles → `level_o[0]`=1 and `press_o[0]` after 6 cycles; `repeat_o[0]` 10 cycles after the press, then every 3 cycles.
- Glitch: ch1 high for 3 cycles, then low → no strobes and `level_o[1]` stays 0. Release glitch of 3 low cycles while pressed → no `release_o`.
- Simultaneous: both channels rise on the same cycle → `press_o`=2'b11 in a single cycle. A staggered release gives independent `release_o` strobes.
- Reset while held: assert `rst_i` for 1 cycle at ch0 PRESSED → all outputs 0 next cycle; `press_o[0]` fires 6 cycles after reset deasserts.
- Sync disabled: rebuild without the macro, press ch0 → `press_o[0]` after 4 cycles.
- DebounceCycles=1 variant: single-cycle high pulse → `press_o` then `release_o`, each exactly once.

Source files
------------

// File: rtl/config_pkg.sv
// Shared definitions for the push-button conditioner: channel state encoding,
// default board timing and a small helper used to size the hold counter.
package config_pkg;

   // Debounce/hold state of a single button channel
   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btn_state_e;

   // Default timing at 25 MHz: 10 ms debounce, 0.5 s hold, 0.1 s repeat
   localparam int BtnDebounceCycles = 250000;
   localparam int BtnHoldCycles     = 12500000;
   localparam int BtnRepeatCycles   = 2500000;

   // Number of flops in the optional input synchroniser
   localparam int BtnSyncStages = 2;

   // Larger of two integers, used when sizing counters at elaboration time
   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: optional two-flop synchroniser, debounce FSM,
// press/release strobes and hold-to-auto-repeat.
// Optional feature macro: BUTTON_SYNC_EN (adds the synchroniser; leave it
// undefined only when btn_i is already synchronous to clk_i).
module button_channel
   import config_pkg::*;
#(
   parameter int DebounceCycles = BtnDebounceCycles,
   parameter int HoldCycles     = BtnHoldCycles,
   parameter int RepeatCycles   = BtnRepeatCycles
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int DebW        = $clog2(DebounceCycles + 1);
   localparam int HoldW       = $clog2(maxInt(HoldCycles, RepeatCycles) + 1);
   localparam int ReloadValue = (HoldCycles > RepeatCycles) ? (HoldCycles - RepeatCycles) : 0;

   localparam logic [DebW-1:0]  DebOne     = DebW'(1);
   localparam logic [DebW:0]    DebLimit   = (DebW + 1)'(DebounceCycles);
   localparam logic [HoldW-1:0] HoldTop    = HoldW'(HoldCycles);
   localparam logic [HoldW-1:0] HoldReload = HoldW'(ReloadValue);

   logic sample;

`ifdef BUTTON_SYNC_EN
   logic [BtnSyncStages-1:0] sync_q;

   // Bring the asynchronous pin into the clock domain through two flops
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[BtnSyncStages-2:0], btn_i};
      end
   end

   assign sample = sync_q[BtnSyncStages-1];
`else
   assign sample = btn_i;
`endif

   btn_state_e       state_q;
   logic [DebW-1:0]  debCnt_q;
   logic [HoldW-1:0] holdCnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic             repeat_q;

   logic [DebW:0]    debNext_d;
   logic [HoldW-1:0] holdNext_d;
   logic             debReach_d;
   logic             debFull_d;
   logic             holdHit_d;

   // debReach_d: this sample completes the required run of stable samples.
   // debFull_d only occurs with a one-sample debounce, where entering the
   // pending state already accepted the change and the pending cycle simply
   // commits it whatever the next sample is.
   assign debNext_d  = {1'b0, debCnt_q} + (DebW + 1)'(1);
   assign debReach_d = (debNext_d >= DebLimit);
   assign debFull_d  = ({1'b0, debCnt_q} >= DebLimit);
   assign holdNext_d = holdCnt_q + HoldW'(1);
   assign holdHit_d  = (holdNext_d == HoldTop);

   // Debounce/repeat state machine with registered level and strobes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= RELEASED;
         debCnt_q  <= '0;
         holdCnt_q <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (sample) begin
                  state_q  <= PRESS_PEND;
                  debCnt_q <= DebOne;
               end
            end
            PRESS_PEND: begin
               if (debFull_d || (sample && debReach_d)) begin
                  state_q   <= PRESSED;
                  debCnt_q  <= '0;
                  holdCnt_q <= '0;
                  level_q   <= 1'b1;
                  press_q   <= 1'b1;
               end else if (!sample) begin
                  state_q  <= RELEASED;
                  debCnt_q <= '0;
               end else begin
                  debCnt_q <= debNext_d[DebW-1:0];
               end
            end
            PRESSED: begin
               if (!sample) begin
                  state_q  <= RELEASE_PEND;
                  debCnt_q <= DebOne;
               end else if (holdHit_d) begin
                  holdCnt_q <= HoldReload;
                  repeat_q  <= 1'b1;
               end else begin
                  holdCnt_q <= holdNext_d;
               end
            end
            RELEASE_PEND: begin
               if (debFull_d || (!sample && debReach_d)) begin
                  state_q   <= RELEASED;
                  debCnt_q  <= '0;
                  holdCnt_q <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else if (sample) begin
                  state_q  <= PRESSED;
                  debCnt_q <= '0;
               end else begin
                  debCnt_q <= debNext_d[DebW-1:0];
               end
            end
            default: begin
               state_q  <= RELEASED;
               debCnt_q <= '0;
            end
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: one independent button_channel per
// front-panel button, all sharing the system clock and reset.
// Optional feature macro: BUTTON_SYNC_EN (per-channel two-flop synchroniser).
module button_conditioner
   import config_pkg::*;
#(
   parameter int NumChannels    = 2,
   parameter int DebounceCycles = BtnDebounceCycles,
   parameter int HoldCycles     = BtnHoldCycles,
   parameter int RepeatCycles   = BtnRepeatCycles
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumChannels-1:0] btn_i,
   output logic [NumChannels-1:0] level_o,
   output logic [NumChannels-1:0] press_o,
   output logic [NumChannels-1:0] release_o,
   output logic [NumChannels-1:0] repeat_o
);

   // Channels never interact, so each bit gets its own conditioner
   for (genvar ch = 0; ch < NumChannels; ch++) begin : gChannel
      button_channel #(
         .DebounceCycles(DebounceCycles),
         .HoldCycles    (HoldCycles),
         .RepeatCycles  (RepeatCycles)
      ) uChannel (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .btn_i    (btn_i[ch]),
         .level_o  (level_o[ch]),
         .press_o  (press_o[ch]),
         .release_o(release_o[ch]),
         .repeat_o (repeat_o[ch])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a 2-channel instance with short
// timing plus a 1-channel instance with a one-sample debounce.
module tb_button_conditioner;

   localparam int Deb  = 4;
   localparam int Hold = 10;
   localparam int Rep  = 3;
`ifdef BUTTON_SYNC_EN
   localparam int SyncDelay = 2;
`else
   localparam int SyncDelay = 0;
`endif
   localparam int Lat = Deb + SyncDelay;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [1:0] btn_i = 2'b00;
   logic [1:0] level_o, press_o, release_o, repeat_o;

   logic [0:0] btnB = 1'b0;
   logic [0:0] levelB, pressB, releaseB, repeatB;

   int compared   = 0;
   int mismatched = 0;
   int pressCnt1   = 0;
   int releaseCnt0 = 0;
   int repeatCnt0  = 0;
   int pressCntB   = 0;
   int releaseCntB = 0;

   button_conditioner #(
      .NumChannels(2), .DebounceCycles(Deb), .HoldCycles(Hold), .RepeatCycles(Rep)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i),
      .level_o(level_o), .press_o(press_o), .release_o(release_o), .repeat_o(repeat_o)
   );

   button_conditioner #(
      .NumChannels(1), .DebounceCycles(1), .HoldCycles(Hold), .RepeatCycles(Rep)
   ) dutB (
      .clk_i(clk_i), .rst_i(rst_i), .btn_i(btnB),
      .level_o(levelB), .press_o(pressB), .release_o(releaseB), .repeat_o(repeatB)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Tally strobes mid-cycle so glitch windows can be checked as totals
   always @(negedge clk_i) begin
      if (press_o[1])   pressCnt1   <= pressCnt1 + 1;
      if (release_o[0]) releaseCnt0 <= releaseCnt0 + 1;
      if (repeat_o[0])  repeatCnt0  <= repeatCnt0 + 1;
      if (pressB[0])    pressCntB   <= pressCntB + 1;
      if (releaseB[0])  releaseCntB <= releaseCntB + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] btn);
      btn_i = btn;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      applyStimulus(2'b00);
      btnB = 1'b0;
      tick(3);
      checkOutput("reset_outputs", {24'd0, level_o, press_o, release_o, repeat_o}, 32'd0);
      rst_i = 1'b0;
      tick(2);
      checkOutput("idle_outputs", {24'd0, level_o, press_o, release_o, repeat_o}, 32'd0);

      // Clean press on ch0 and auto-repeat
      applyStimulus(2'b01);
      tick(Lat - 1);
      checkOutput("press_early", {30'd0, press_o}, 32'd0);
      checkOutput("level_early", {30'd0, level_o}, 32'd0);
      tick(1);
      checkOutput("press_ch0", {30'd0, press_o}, 32'd1);
      checkOutput("level_ch0", {30'd0, level_o}, 32'd1);
      tick(1);
      checkOutput("press_one_cycle", {30'd0, press_o}, 32'd0);
      tick(Hold - 2);
      checkOutput("repeat_early", {30'd0, repeat_o}, 32'd0);
      tick(1);
      checkOutput("repeat_first", {30'd0, repeat_o}, 32'd1);
      tick(Rep - 1);
      checkOutput("repeat_gap", {30'd0, repeat_o}, 32'd0);
      tick(1);
      checkOutput("repeat_second", {30'd0, repeat_o}, 32'd1);
      tick(3 * Rep);
      checkOutput("repeat_fifth", {30'd0, repeat_o}, 32'd1);
      checkOutput("repeat_count", repeatCnt0, 32'd4);

      // Short low glitch while ch0 is pressed
      applyStimulus(2'b00);
      tick(3);
      applyStimulus(2'b01);
      tick(8);
      checkOutput("rel_glitch_count", releaseCnt0, 32'd0);
      checkOutput("rel_glitch_level", {30'd0, level_o}, 32'd1);

      // Real release of ch0
      applyStimulus(2'b00);
      tick(Lat - 1);
      checkOutput("release_early", {30'd0, release_o}, 32'd0);
      checkOutput("level_still_high", {30'd0, level_o}, 32'd1);
      tick(1);
      checkOutput("release_ch0", {30'd0, release_o}, 32'd1);
      checkOutput("level_low_ch0", {30'd0, level_o}, 32'd0);
      tick(1);
      checkOutput("release_one_cycle", {30'd0, release_o}, 32'd0);
      tick(3);

      // Short high glitch on ch1
      applyStimulus(2'b10);
      tick(3);
      applyStimulus(2'b00);
      tick(Lat + 4);
      checkOutput("press_glitch_count", pressCnt1, 32'd0);
      checkOutput("press_glitch_level", {30'd0, level_o}, 32'd0);

      // Simultaneous press, staggered release
      applyStimulus(2'b11);
      tick(Lat);
      checkOutput("press_both", {30'd0, press_o}, 32'd3);
      checkOutput("level_both", {30'd0, level_o}, 32'd3);
      tick(2);
      applyStimulus(2'b10);
      tick(2);
      applyStimulus(2'b00);
      tick(Lat - 2);
      checkOutput("release_stag0", {30'd0, release_o}, 32'd1);
      checkOutput("level_stag0", {30'd0, level_o}, 32'd2);
      tick(2);
      checkOutput("release_stag1", {30'd0, release_o}, 32'd2);
      checkOutput("level_stag1", {30'd0, level_o}, 32'd0);
      tick(3);

      // Reset while ch0 is held
      applyStimulus(2'b01);
      tick(Lat + 2);
      checkOutput("held_before_reset", {30'd0, level_o}, 32'd1);
      rst_i = 1'b1;
      tick(1);
      checkOutput("reset_held_outputs", {24'd0, level_o, press_o, release_o, repeat_o}, 32'd0);
      rst_i = 1'b0;
      tick(Lat - 1);
      checkOutput("repress_early", {30'd0, press_o}, 32'd0);
      tick(1);
      checkOutput("repress_ch0", {30'd0, press_o}, 32'd1);
      applyStimulus(2'b00);
      tick(Lat + 2);

      // One-sample debounce: single-cycle pulse
      btnB = 1'b1;
      tick(1);
      btnB = 1'b0;
      tick(1 + SyncDelay);
      checkOutput("d1_press", {31'd0, pressB}, 32'd1);
      checkOutput("d1_level_high", {31'd0, levelB}, 32'd1);
      tick(1);
      checkOutput("d1_press_over", {31'd0, pressB}, 32'd0);
      tick(1);
      checkOutput("d1_release", {31'd0, releaseB}, 32'd1);
      checkOutput("d1_level_low", {31'd0, levelB}, 32'd0);
      tick(5);
      checkOutput("d1_press_count", pressCntB, 32'd1);
      checkOutput("d1_release_count", releaseCntB, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
